// File: rtl/nibble_serial_adder_ctrl.sv
// Sequencer that adds two W-bit operands through an external 4-bit ripple-carry adder,
// one nibble per clock, least-significant nibble first, chaining the carry through a flop.
module nibble_serial_adder_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic [3:0]             add_x,
    output logic [3:0]             add_y,
    output logic                   add_cin,
    input  logic [3:0]             add_s,
    input  logic                   add_cout,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [W-1:0]    res_r;
    logic            carry_r;
    logic [IW-1:0]   idx;
    logic [W-1:0]    res_next;

    // New sum nibble enters at the top; written as shifts so NIBBLES=1 needs no empty slice.
    assign res_next = (res_r >> 4) | (W'(add_s) << (W - 4));

    // Adder inputs come only from registers (busy is a flop), so no loop through the adder.
    assign add_x   = busy ? a_r[3:0] : 4'h0;
    assign add_y   = busy ? b_r[3:0] : 4'h0;
    assign add_cin = busy & carry_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            res_r   <= '0;
            carry_r <= 1'b0;
            idx     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin;
                        idx     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    res_r   <= res_next;
                    a_r     <= a_r >> 4;
                    b_r     <= b_r >> 4;
                    carry_r <= add_cout;
                    idx     <= idx + IW'(1);
                    if (idx == IW'(NIBBLES - 1)) begin
                        sum   <= res_next;
                        cout  <= add_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl at NIBBLES=4 and NIBBLES=1, each wired
// to a behavioural 4-bit ripple-carry adder built from full-adder stages.
module tb_nibble_serial_adder_ctrl;

    logic        clk;
    logic        rst;

    logic        start, cin, add_cin, add_cout, cout, busy, done;
    logic [15:0] a, b, sum;
    logic [3:0]  add_x, add_y, add_s;

    logic        start1, cin1, add_cin1, add_cout1, cout1, busy1, done1;
    logic [3:0]  a1, b1, sum1, add_x1, add_y1, add_s1;

    logic        c0, c1;
    int          checks;
    int          errors;

    nibble_serial_adder_ctrl #(.NIBBLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .sum(sum), .cout(cout), .busy(busy), .done(done)
    );

    nibble_serial_adder_ctrl #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .add_x(add_x1), .add_y(add_y1), .add_cin(add_cin1),
        .add_s(add_s1), .add_cout(add_cout1),
        .sum(sum1), .cout(cout1), .busy(busy1), .done(done1)
    );

    // Ripple-carry adders: four full-adder stages each.
    always_comb begin
        c0    = add_cin;
        add_s = 4'h0;
        for (int i = 0; i < 4; i++) begin
            add_s[i] = add_x[i] ^ add_y[i] ^ c0;
            c0       = (add_x[i] & add_y[i]) | (c0 & (add_x[i] ^ add_y[i]));
        end
        add_cout = c0;
    end

    always_comb begin
        c1     = add_cin1;
        add_s1 = 4'h0;
        for (int i = 0; i < 4; i++) begin
            add_s1[i] = add_x1[i] ^ add_y1[i] ^ c1;
            c1        = (add_x1[i] & add_y1[i]) | (c1 & (add_x1[i] ^ add_y1[i]));
        end
        add_cout1 = c1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulses start for one cycle, waits (bounded) for done, then steps one more cycle back to IDLE.
    task automatic run_add(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                           output logic [15:0] rs, output logic rc, output int lat,
                           output int bcnt, output logic dafter);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; bcnt = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        rs = sum; rc = cout;
        @(posedge clk); #1;
        dafter = done;
    endtask

    task automatic test_reset();
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({sum, cout, busy, done, add_x, add_y, add_cin} !== 31'h0) begin
            errors++;
            $display("FAIL reset_outputs: got sum=%h cout=%b busy=%b done=%b x=%h y=%h ci=%b, expected all 0",
                     sum, cout, busy, done, add_x, add_y, add_cin);
        end
        checks++;
        if ({sum1, cout1, busy1, done1} !== 7'h0) begin
            errors++;
            $display("FAIL reset_outputs_n1: got sum=%h cout=%b busy=%b done=%b, expected all 0",
                     sum1, cout1, busy1, done1);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle: got busy=%b done=%b, expected 0 0", busy, done);
            end
        end
    endtask

    task automatic test_basic();
        logic [15:0] rs; logic rc; int lat; int bcnt; logic da;
        run_add(16'h1234, 16'h1111, 1'b0, rs, rc, lat, bcnt, da);
        checks++;
        if (rs !== 16'h2345 || rc !== 1'b0) begin
            errors++;
            $display("FAIL basic_sum: got %b_%h, expected 0_2345", rc, rs);
        end
        checks++;
        if (lat != 4 || bcnt != 4) begin
            errors++;
            $display("FAIL basic_timing: got latency=%0d busy_cycles=%0d, expected 4 4", lat, bcnt);
        end
        checks++;
        if (da !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: got done=%b busy=%b after pulse, expected 0 0", da, busy);
        end
    endtask

    task automatic test_datapath();
        int n;
        a = 16'h00F8; b = 16'h0009; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (add_x !== 4'h8 || add_y !== 4'h9 || add_cin !== 1'b0) begin
            errors++;
            $display("FAIL nibble0_drive: got x=%h y=%h ci=%b, expected 8 9 0", add_x, add_y, add_cin);
        end
        @(posedge clk); #1;
        checks++;
        if (add_x !== 4'hF || add_y !== 4'h0 || add_cin !== 1'b1) begin
            errors++;
            $display("FAIL nibble1_drive: got x=%h y=%h ci=%b, expected f 0 1", add_x, add_y, add_cin);
        end
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (sum !== 16'h0101 || cout !== 1'b0 || n != 3) begin
            errors++;
            $display("FAIL datapath_sum: got %b_%h after %0d more cycles, expected 0_0101 after 3",
                     cout, sum, n);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_carry_chain();
        logic [15:0] rs; logic rc; int lat; int bcnt; logic da;
        run_add(16'hFFFF, 16'h0001, 1'b0, rs, rc, lat, bcnt, da);
        checks++;
        if (rs !== 16'h0000 || rc !== 1'b1 || lat != 4) begin
            errors++;
            $display("FAIL carry_ffff_0001: got %b_%h lat=%0d, expected 1_0000 lat=4", rc, rs, lat);
        end
        run_add(16'hFFFF, 16'hFFFF, 1'b1, rs, rc, lat, bcnt, da);
        checks++;
        if (rs !== 16'hFFFF || rc !== 1'b1 || lat != 4) begin
            errors++;
            $display("FAIL carry_ffff_ffff_1: got %b_%h lat=%0d, expected 1_ffff lat=4", rc, rs, lat);
        end
        checks++;
        if (add_cin !== 1'b0 || add_x !== 4'h0 || add_y !== 4'h0) begin
            errors++;
            $display("FAIL idle_adder_drive: got x=%h y=%h ci=%b, expected 0 0 0", add_x, add_y, add_cin);
        end
    endtask

    task automatic test_ignored_start();
        logic [15:0] rs; logic rc; int dcnt;
        rs = 16'hDEAD; rc = 1'b1; dcnt = 0;
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                dcnt++;
                rs = sum; rc = cout;
            end
            if (k == 1) begin
                a = 16'h1111; start = 1'b1;
            end else if (k == 2) begin
                start = 1'b0;
            end
        end
        checks++;
        if (dcnt != 1 || rs !== 16'h0100 || rc !== 1'b0) begin
            errors++;
            $display("FAIL ignored_start: got %0d done pulses sum=%b_%h, expected 1 pulse 0_0100", dcnt, rc, rs);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_start_idle: got busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int d1; int d2;
        d1 = -1; d2 = -1;
        a = 16'h0001; b = 16'h0002; cin = 1'b0; start = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                if (d1 < 0) d1 = k;
                else if (d2 < 0) d2 = k;
            end
        end
        start = 1'b0;
        checks++;
        if (d1 != 4 || d2 != 10) begin
            errors++;
            $display("FAIL held_start_spacing: got done at %0d and %0d, expected 4 and 10", d1, d2);
        end
        checks++;
        if (sum !== 16'h0003 || cout !== 1'b0) begin
            errors++;
            $display("FAIL held_start_sum: got %b_%h, expected 0_0003", cout, sum);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL held_start_release: got busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [15:0] rs; logic rc; int lat; int bcnt; logic da; int dcnt;
        a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({sum, cout, busy, done, add_x, add_y, add_cin} !== 31'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got sum=%h cout=%b busy=%b done=%b x=%h y=%h ci=%b, expected all 0",
                     sum, cout, busy, done, add_x, add_y, add_cin);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) dcnt++;
        end
        checks++;
        if (dcnt != 0 || sum !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset_abandon: got %0d active cycles sum=%h, expected 0 and 0000", dcnt, sum);
        end
        run_add(16'h0008, 16'h0008, 1'b0, rs, rc, lat, bcnt, da);
        checks++;
        if (rs !== 16'h0010 || rc !== 1'b0 || lat != 4) begin
            errors++;
            $display("FAIL mid_reset_restart: got %b_%h lat=%0d, expected 0_0010 lat=4", rc, rs, lat);
        end
    endtask

    task automatic test_random();
        logic [15:0] ra; logic [15:0] rb; logic rci;
        logic [15:0] rs; logic rc; int lat; int bcnt; logic da;
        logic [16:0] expv;
        for (int n = 0; n < 200; n++) begin
            ra   = 16'($urandom());
            rb   = 16'($urandom());
            rci  = 1'($urandom_range(0, 1));
            expv = 17'(ra) + 17'(rb) + 17'(rci);
            run_add(ra, rb, rci, rs, rc, lat, bcnt, da);
            checks++;
            if ({rc, rs} !== expv || lat != 4) begin
                errors++;
                $display("FAIL random_%0d: %h+%h+%b got %h lat=%0d, expected %h lat=4",
                         n, ra, rb, rci, {rc, rs}, lat, expv);
            end
        end
    endtask

    task automatic test_single_nibble();
        a1 = 4'h9; b1 = 4'h8; cin1 = 1'b0; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        checks++;
        if (busy1 !== 1'b1 || done1 !== 1'b0 || add_x1 !== 4'h9 || add_y1 !== 4'h8) begin
            errors++;
            $display("FAIL n1_run: got busy=%b done=%b x=%h y=%h, expected 1 0 9 8", busy1, done1, add_x1, add_y1);
        end
        @(posedge clk); #1;
        checks++;
        if (done1 !== 1'b1 || busy1 !== 1'b0 || sum1 !== 4'h1 || cout1 !== 1'b1) begin
            errors++;
            $display("FAIL n1_done: got done=%b busy=%b sum=%b_%h, expected 1 0 1_1", done1, busy1, cout1, sum1);
        end
        @(posedge clk); #1;
        checks++;
        if (done1 !== 1'b0) begin
            errors++;
            $display("FAIL n1_pulse: got done=%b, expected 0", done1);
        end
        a1 = 4'hF; b1 = 4'hF; cin1 = 1'b1; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (done1 !== 1'b1 || sum1 !== 4'hF || cout1 !== 1'b1) begin
            errors++;
            $display("FAIL n1_carry: got done=%b sum=%b_%h, expected 1 1_f", done1, cout1, sum1);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b0;
        start = 1'b0; a = 16'h0; b = 16'h0; cin = 1'b0;
        start1 = 1'b0; a1 = 4'h0; b1 = 4'h0; cin1 = 1'b0;
        test_reset();
        test_basic();
        test_datapath();
        test_carry_chain();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        test_single_nibble();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
